// File: rtl/div_radix2_if.sv
// div_radix2_if: operand/result bundle between the execute stage and the
// radix-2 divider. The master side issues operations, the slave side is
// the divider itself.
interface div_radix2_if #(
  parameter int XLEN = 32
);
  logic            Enable;
  logic [11:0]     funct3;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] rd;
  logic            Busy;
  logic            Done;

  modport master (
    output Enable, funct3, rs1, rs2,
    input  rd, Busy, Done
  );

  modport slave (
    input  Enable, funct3, rs1, rs2,
    output rd, Busy, Done
  );
endinterface

// File: rtl/div_radix2.sv
// div_radix2: iterative RV32M DIV/DIVU/REM/REMU using a radix-2 restoring
// algorithm, one quotient bit per clock.
// Flow: IDLE -> PREP -> CALC (32 iterations) -> FIX -> IDLE, 34 cycles.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip
// CALC and complete in 2 cycles; results are identical either way.
module div_radix2 #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic          clk,
  input  logic          reset,  // asynchronous, active-low
  div_radix2_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;      // {is_rem, is_unsigned} = funct3[8:7]
  logic [XLEN-1:0] a_q, a_d;        // raw dividend as accepted
  logic [XLEN-1:0] b_q, b_d;        // raw divisor as accepted
  logic [XLEN-1:0] quo_q, quo_d;    // dividend shifting out / quotient in
  logic [XLEN-1:0] dvs_q, dvs_d;    // magnitude of the divisor
  logic [XLEN:0]   rem_q, rem_d;    // 33-bit partial remainder
  logic [4:0]      cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            done_q, done_d;

  logic            legal_start;
  logic            launch;
  logic            op_signed;
  logic            dz_now;
  logic            ovf_now;
  logic [XLEN:0]   rem_sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quo_res;
  logic [XLEN-1:0] rem_res;

  // Only the four M-extension divide codes start an operation.
  assign legal_start = bus.Enable
                     && (bus.funct3[11:10] == 2'b01)
                     && (bus.funct3[6:0] == 7'b0110011)
                     && bus.funct3[9];

  // A new operation may be taken in IDLE, or in FIX for back-to-back issue.
  assign launch    = legal_start && ((state_q == S_IDLE) || (state_q == S_FIX));
  assign op_signed = ~op_q[0];

  // Special cases seen from the latched raw operands.
  assign dz_now  = (b_q == '0);
  assign ovf_now = op_signed && (a_q == INT_MIN) && (b_q == ALL_ONE);

  // One restoring step: shift {rem, quo} left, trial-subtract the divisor.
  assign rem_sh = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // Signed results are corrected from the unsigned magnitudes.
  assign quo_res = (op_signed && qneg_q) ? -quo_q : quo_q;
  assign rem_res = (op_signed && rneg_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  // Next-state and datapath updates for the divider FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    rd_d    = rd_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end

      S_PREP: begin
        quo_d   = (op_signed && a_q[XLEN-1]) ? -a_q : a_q;
        dvs_d   = (op_signed && b_q[XLEN-1]) ? -b_q : b_q;
        qneg_d  = a_q[XLEN-1] ^ b_q[XLEN-1];
        rneg_d  = a_q[XLEN-1];
        dz_d    = dz_now;
        ovf_d   = ovf_now;
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_CALC;
`ifdef DIV_EARLY_OUT_EN
        if (dz_now || ovf_now) begin
          state_d = S_FIX;
        end
`endif
      end

      S_CALC: begin
        if (!diff[XLEN]) begin
          rem_d = diff;
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (dz_q) begin
          rd_d = op_q[1] ? a_q : ALL_ONE;
        end else if (ovf_q) begin
          rd_d = op_q[1] ? '0 : INT_MIN;
        end else begin
          rd_d = op_q[1] ? rem_res : quo_res;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Acceptance overrides the IDLE/FIX transition; operands are captured
    // so later input changes cannot disturb the running operation.
    if (launch) begin
      a_d     = bus.rs1;
      b_d     = bus.rs2;
      op_d    = bus.funct3[8:7];
      state_d = S_PREP;
    end
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values,
      // which is what the parallel hardware does.
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      done_q  <= done_d;
    end
  end

  assign bus.rd   = rd_q;
  assign bus.Done = done_q;
  assign bus.Busy = (state_q != S_IDLE);

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative 32-bit integer divider implementing the RV32M DIV, DIVU, REM and REMU operations with a radix-2 restoring algorithm. It is the inverse-operation companion to the Booth/Karatsuba multiplier and sits beside it in the execute stage. It uses the same operand and opcode conventions: a 12-bit `{2'b01, funct3, 7'b0110011}` code selects the operation. Each operation runs one quotient bit per clock, with a fixed 34-cycle latency by default.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  start request; sampled only in IDLE.
- `funct3`  in  12  operation code: DIV `12'b011000110011`, DIVU `12'b011010110011`, REM `12'b011100110011`, REMU `12'b011110110011`.
- `rs1`  in  32  dividend.
- `rs2`  in  32  divisor.
- `rd`  out  32  result; holds its value until the next completion.
- `Busy`  out  1  high while an operation is in flight.
- `Done`  out  1  one-cycle pulse, asserted in the cycle `rd` first shows a new result.

## Operation
- Reset values: `rd=0`, `Busy=0`, `Done=0`, state IDLE, all internal registers cleared.
- States: IDLE → PREP → CALC → FIX → IDLE.
- IDLE:
  - `Enable=1` with a legal code latches `rs1`, `rs2` and the code, then moves to PREP.
  - An illegal code or `Enable=0` stays in IDLE; `rd` is unchanged.
- PREP:
  - Signed ops (DIV/REM): take the absolute value of each operand.
  - Record `qneg = rs1[31]^rs2[31]` and `rneg = rs1[31]`.
  - Flag `dz` (divisor == 0) and `ovf` (DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF).
  - Clear the 33-bit partial remainder and the iteration counter.
- CALC: 32 iterations, one per clock, 5-bit counter 0..31.
  - Shift `{rem, quo}` left by 1.
  - Trial-subtract the divisor from the 33-bit remainder.
  - If the result is non-negative, keep it and set `quo[0]=1`.
  - At count 31, go to FIX.
- FIX: apply signs and special cases, load `rd`, pulse `Done`, return to IDLE.
  - `dz` case: DIV/DIVU → 0xFFFFFFFF; REM/REMU → `rs1`, raw and unsigned-unmodified.
  - `ovf` case: DIV → 0x80000000; REM → 0.
  - Otherwise: quotient is negated if `qneg` (signed ops only); remainder is negated if `rneg` (signed ops only).
- `Enable` during `Busy` is ignored; there is no queuing. Input changes after acceptance have no effect.
- Asynchronous reset mid-operation aborts immediately: outputs return to reset values and no `Done` is issued.

## Timing
- The acceptance edge is E0.
- `Busy` is high from after E0 through E34, and low after E34.
- `rd` and `Done` are registered at E34, so the latency is 34 cycles.
- `Done` is high for exactly one cycle, E34 to E35.
- A new `Enable` is accepted no earlier than E34. If `Enable` is high at E34, the unit re-launches back-to-back and `Done` and the new `Busy` overlap for one cycle.
- `Busy` deasserts in the same cycle `Done` asserts.

## Configuration
- `DIV_EARLY_OUT_EN`:
  - Defined: when PREP detects `dz` or `ovf`, the unit skips CALC and goes straight to FIX. `rd` and `Done` then land at E2 and `Busy` drops after E2.
  - Undefined: every operation takes the full 34 cycles; the special-case values are identical in both builds, only the latency differs.

## Test plan
- DIVU rs1=100, rs2=7 → `rd=14`, `Done` at E34, `Busy` high for exactly 34 cycles.
- REM rs1=-7 (0xFFFFFFF9), rs2=2 → `rd=0xFFFFFFFF` (-1); DIV with the same operands → `rd=0xFFFFFFFD` (-3).
- DIV rs2=0, rs1=5 → `rd=0xFFFFFFFF`; REMU rs2=0, rs1=5 → `rd=5`. Check latency E34 without the macro, E2 with `DIV_EARLY_OUT_EN`.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF → `rd=0x80000000`; REM with the same operands → `rd=0`. No X or overflow artefacts.
- Pulse `Enable` with a different code at E10 → ignored, first result unaffected. Use an illegal code `12'b010000110011` while IDLE → no `Busy`, `rd` unchanged.
- Assert `reset` low at E20 of a DIVU → `Busy=0`, `rd=0`, no `Done`. After release, a fresh DIVU 0xFFFFFFFF/1 → `rd=0xFFFFFFFF`.
